fir_seq_ctrl: RTL

- Sequencer that sits directly in front of the 51-tap FIR datapath. It owns the filter's enable, sample input and tap-write port.
- In normal operation it forwards upstream samples to the filter as single-cycle enable pulses and flags which filter outputs are valid.
- On request it runs a coefficient reload: it stalls sample intake, streams ORDER+1 new taps into the filter, then flushes the delay line with zeros so no stale history mixes with the new response, and resumes.

---
 rtl/fir_seq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/fir_seq_ctrl.sv
// Sequencer in front of the 51-tap FIR: forwards samples as enable pulses and
// runs coefficient reloads followed by a zero flush of the filter delay line.
module fir_seq_ctrl #(
    parameter int ORDER          = 50,
    parameter int DATA_IN_WIDTH  = 16,
    parameter int TAP_DATA_WIDTH = 16,
    parameter int TAP_ADDR_WIDTH = 6,
    parameter int FLUSH_LEN      = ORDER + 3
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_smp_valid,
    input  logic signed [DATA_IN_WIDTH-1:0]  i_smp_data,
    output logic                             o_smp_ready,
    input  logic                             i_cfg_start,
    input  logic                             i_coef_valid,
    input  logic [TAP_DATA_WIDTH-1:0]        i_coef_data,
    output logic                             o_coef_ready,
    output logic                             o_fir_en,
    output logic signed [DATA_IN_WIDTH-1:0]  o_fir_data,
    output logic                             o_tap_wr_en,
    output logic [TAP_ADDR_WIDTH-1:0]        o_tap_wr_addr,
    output logic [TAP_DATA_WIDTH-1:0]        o_tap_wr_data,
    output logic                             o_out_valid,
    output logic                             o_busy,
    output logic                             o_cfg_done,
    output logic [15:0]                      o_drop_cnt
);

    localparam int FLUSH_W = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t                    state;
    logic [TAP_ADDR_WIDTH-1:0] coef_idx;
    logic [FLUSH_W-1:0]        flush_cnt;
    logic                      run_pulse;

    assign o_smp_ready  = (state == RUN);
    assign o_coef_ready = (state == LOAD);
    assign o_busy       = (state != RUN);

    // run_pulse marks an enable that came from a real sample, so flush pulses
    // never produce o_out_valid one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= RUN;
            coef_idx      <= '0;
            flush_cnt     <= '0;
            run_pulse     <= 1'b0;
            o_fir_en      <= 1'b0;
            o_fir_data    <= '0;
            o_tap_wr_en   <= 1'b0;
            o_tap_wr_addr <= '0;
            o_tap_wr_data <= '0;
            o_out_valid   <= 1'b0;
            o_cfg_done    <= 1'b0;
            o_drop_cnt    <= '0;
        end else begin
            o_fir_en    <= 1'b0;
            o_tap_wr_en <= 1'b0;
            o_cfg_done  <= 1'b0;
            run_pulse   <= 1'b0;
            o_out_valid <= o_fir_en && run_pulse;

            if (i_smp_valid && o_busy && (o_drop_cnt != 16'hFFFF))
                o_drop_cnt <= o_drop_cnt + 16'd1;

            case (state)
                RUN: begin
                    if (i_smp_valid) begin
                        o_fir_en   <= 1'b1;
                        o_fir_data <= i_smp_data;
                        run_pulse  <= 1'b1;
                    end
                    if (i_cfg_start) begin
                        state    <= LOAD;
                        coef_idx <= '0;
                    end
                end
                LOAD: begin
                    if (i_coef_valid) begin
                        o_tap_wr_en   <= 1'b1;
                        o_tap_wr_addr <= coef_idx;
                        o_tap_wr_data <= i_coef_data;
                        if (coef_idx == TAP_ADDR_WIDTH'(ORDER))
                            state <= SETTLE;
                        else
                            coef_idx <= coef_idx + 1'b1;
                    end
                end
                SETTLE: begin
                    state     <= FLUSH;
                    flush_cnt <= '0;
                end
                FLUSH: begin
                    o_fir_en   <= 1'b1;
                    o_fir_data <= '0;
                    if (flush_cnt == FLUSH_W'(FLUSH_LEN - 1)) begin
                        state      <= RUN;
                        o_cfg_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
